gf163_mult_ctrl: RTL and testbench
==================================

Name: gf163_mult_ctrl

Overview:
Sequencer that computes a full GF(2^163) field product c = a·b mod f(x), with f(x) = x^163 + x^7 + x^6 + x^3 + 1. It time-shares one external pipelined 82x82 GF(2) polynomial multiplier (no reduction) across three Karatsuba passes. It then recombines the three partial products and reduces the result. It sits between the point-arithmetic layer (valid/ready on both sides) and the shared multiplier instance.

Parameters:
MUL_LAT, 1, cycles from driving mul_a/mul_b to the matching product on mul_d (0 = combinational multiplier); legal range 0..7.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  controller idle, can accept operands
in_a  in  163  operand a, polynomial basis, bit i = coeff of x^i
in_b  in  163  operand b
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_c  out  163  a·b mod f
mul_a  out  82  multiplier operand a
mul_b  out  82  multiplier operand b
mul_issue  out  1  high on cycles where mul_a/mul_b carry a real pass (multiplier clock-enable/debug)
mul_d  in  163  multiplier product, degree ≤ 162

Behaviour:
- Reset (asynchronous, active-high) values: in_ready=0 while rst is high and 1 in the first cycle after release; out_valid=0; out_c=0; mul_a=0; mul_b=0; mul_issue=0; state=IDLE; all partial-product registers=0.
- Split: a_lo=a[81:0], a_hi=a[162:82] (81 bits); b likewise. Pass P0=a_lo·b_lo; P2={0,a_hi}·{0,b_hi}; P1=(a_lo^{0,a_hi})·(b_lo^{0,b_hi}).
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b and go to ISSUE0.
  - ISSUE0 / ISSUE1 / ISSUE2: drive P0, P2 and P1 operands, one per cycle, with mul_issue=1. Then go to WAIT.
  - WAIT: capture mul_d into z0/z2/z1 exactly MUL_LAT cycles after each respective issue cycle. Use an internal 3-bit issue-tag shift/counter, not a comparison on mul_d. Go to REDUCE after the z1 capture.
  - REDUCE: one cycle. p = (z2<<164) ^ ((z0^z1^z2)<<82) ^ z0 (325 bits, degree ≤ 324). out_c ← p mod f, uniquely reduced (degree < 163). The fold structure is free; the result must be canonical. Go to OUT.
  - OUT: out_valid=1, out_c stable until out_valid&out_ready. Then go to IDLE next cycle.
- For MUL_LAT=0, the capture happens in the same cycle as the issue, so WAIT lasts 0 cycles.
- Latency: the handshake occurs in cycle T. out_valid rises in cycle T+5+MUL_LAT. Throughput is one product per 6+MUL_LAT cycles under out_ready=1.
- in_ready=0 in every state except IDLE. in_valid during busy is ignored (no queuing). in_a/in_b are sampled only on the handshake.
- mul_a/mul_b hold their last value when mul_issue=0. The controller never issues when not in ISSUEx.
- Backpressure: out_ready low holds OUT indefinitely with out_c unchanged. No new operands are accepted.
- out_ready with out_valid=0 has no effect.
- rst asserted mid-operation: immediate return to reset values. Products still in the multiplier pipeline are discarded by the tag counter reset and never captured.
- Operands ≥ degree 163 cannot occur (163-bit ports). The inputs are not required to be reduced beyond that.

Test Plan:
- MUL_LAT=1, a=1, b=1 -> out_c=1; out_valid rises exactly 6 cycles after the input handshake; mul_issue high for exactly 3 consecutive cycles.
- a=x^162 (bit 162 only), b=x (0x2) -> out_c=0xC9 (x^7+x^6+x^3+1). a=x^162, b=x^162 -> out_c equals the bench reference-model value; checks double fold.
- Random 1000 pairs at MUL_LAT∈{0,1,3} vs a bit-serial shift-and-add reference -> all match. Latency is 5+MUL_LAT in every case.
- Hold out_ready=0 for 20 cycles after out_valid -> out_c stable, in_ready=0, in_valid pulses ignored. Release -> one transfer, in_ready=1 the next cycle.
- Assert rst in the WAIT state with MUL_LAT=3. Then start a=0x3, b=0x5 -> out_c=0xF (x^3+x^2+x+1). No stale partial products.
- a=all-ones(163), b=1 -> out_c=a. a=0, b=random -> out_c=0.

Source files
------------

// File: rtl/gf163_mult_ctrl_if.sv
// rtl/gf163_mult_ctrl_if.sv - operand/result handshake and shared-multiplier bus of gf163_mult_ctrl
interface gf163_mult_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [162:0] in_a;
    logic [162:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] out_c;
    logic [81:0]  mul_a;
    logic [81:0]  mul_b;
    logic         mul_issue;
    logic [162:0] mul_d;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_d,
        output in_ready, out_valid, out_c, mul_a, mul_b, mul_issue
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_d,
        input  in_ready, out_valid, out_c, mul_a, mul_b, mul_issue
    );
endinterface

// File: rtl/gf163_mult_ctrl.sv
// rtl/gf163_mult_ctrl.sv - GF(2^163) multiply: three Karatsuba passes on a shared 82x82 multiplier, then reduction
module gf163_mult_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    gf163_mult_ctrl_if.slave bus_io
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_ISSUE1, S_ISSUE2, S_WAIT, S_REDUCE, S_OUT
    } state_e;

    state_e       state_q, state_d;
    logic         rdy_q, rdy_d;
    logic [162:0] a_q, a_d, b_q, b_d;
    logic [162:0] z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
    logic [162:0] c_q, c_d;
    logic [81:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [2:0]   issue_tag, cap_tag;
    logic [162:0] c_red;

    // One-hot tag per pass: bit0 = z0 (P0), bit1 = z2 (P2), bit2 = z1 (P1)
    assign issue_tag = {state_q == S_ISSUE2, state_q == S_ISSUE1, state_q == S_ISSUE0};

    // The tag travels alongside the multiplier pipeline; clearing it on reset drops in-flight products
    generate
        if (MUL_LAT == 0) begin : g_tag_comb
            assign cap_tag = issue_tag;
        end else begin : g_tag_pipe
            logic [2:0] tag_q [MUL_LAT];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
                end else begin
                    tag_q[0] <= issue_tag;
                    for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
                end
            end
            assign cap_tag = tag_q[MUL_LAT-1];
        end
    endgenerate

    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        case (state_q)
            S_ISSUE0: begin
                mul_a_d = a_q[81:0];
                mul_b_d = b_q[81:0];
            end
            S_ISSUE1: begin
                mul_a_d = {1'b0, a_q[162:82]};
                mul_b_d = {1'b0, b_q[162:82]};
            end
            S_ISSUE2: begin
                mul_a_d = a_q[81:0] ^ {1'b0, a_q[162:82]};
                mul_b_d = b_q[81:0] ^ {1'b0, b_q[162:82]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (rdy_q && bus_io.in_valid) begin
                    a_d     = bus_io.in_a;
                    b_d     = bus_io.in_b;
                    state_d = S_ISSUE0;
                end
            end
            S_ISSUE0: state_d = S_ISSUE1;
            S_ISSUE1: state_d = S_ISSUE2;
            S_ISSUE2: state_d = S_WAIT;
            S_WAIT:   state_d = S_WAIT;
            S_REDUCE: begin
                c_d     = c_red;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus_io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cap_tag[0]) z0_d = bus_io.mul_d;
        if (cap_tag[1]) z2_d = bus_io.mul_d;
        // P1 is issued last, so its capture also ends the wait (same cycle as ISSUE2 when MUL_LAT is 0)
        if (cap_tag[2]) begin
            z1_d    = bus_io.mul_d;
            state_d = S_REDUCE;
        end
    end

    assign rdy_d = (state_d == S_IDLE);

    // Karatsuba recombination, then two folds of x^163 = x^7 + x^6 + x^3 + 1; the second fold leaves degree <= 14
    logic [326:0] p;
    logic [163:0] h;
    logic [170:0] f1;
    logic [7:0]   h2;
    always_comb begin
        p     = {z2_q, 164'b0} ^ {82'b0, z0_q ^ z1_q ^ z2_q, 82'b0} ^ {164'b0, z0_q};
        h     = p[326:163];
        f1    = {8'b0, p[162:0]} ^ {7'b0, h} ^ {4'b0, h, 3'b0} ^ {1'b0, h, 6'b0} ^ {h, 7'b0};
        h2    = f1[170:163];
        c_red = f1[162:0] ^ {155'b0, h2} ^ {152'b0, h2, 3'b0}
              ^ {149'b0, h2, 6'b0} ^ {148'b0, h2, 7'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            z2_q    <= '0;
            c_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            c_q     <= c_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign bus_io.in_ready  = rdy_q;
    assign bus_io.out_valid = (state_q == S_OUT);
    assign bus_io.out_c     = c_q;
    assign bus_io.mul_a     = mul_a_d;
    assign bus_io.mul_b     = mul_b_d;
    assign bus_io.mul_issue = |issue_tag;
endmodule

// File: tb/tb_gf163_mult_ctrl.sv
// tb/tb_gf163_mult_ctrl.sv - self-checking bench for gf163_mult_ctrl at MUL_LAT 0, 1 and 3
module tb_gf163_mult_ctrl;
    localparam int NI = 3;

    typedef struct {
        logic [162:0] a;
        logic [162:0] b;
        logic [162:0] c;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [162:0] in_a = '0;
    logic [162:0] in_b = '0;
    logic         out_ready = 1'b0;
    logic [162:0] junk = '0;

    logic         rdy_w [NI];
    logic         ov_w  [NI];
    logic         iss_w [NI];
    logic [162:0] oc_w  [NI];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int t0 = 0;
    logic [162:0] got_c [NI];
    int  got_lat   [NI];
    bit  done      [NI];
    int  iss_cnt   [NI];
    int  iss_first [NI];
    int  iss_last  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    function automatic logic [162:0] clmul(input logic [81:0] a, input logic [81:0] b);
        logic [162:0] r;
        r = '0;
        for (int i = 0; i < 82; i++)
            if (b[i]) r = r ^ ({81'b0, a} << i);
        return r;
    endfunction

    function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
        logic [163:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = r << 1;
            if (r[163]) r = r ^ {1'b1, 155'b0, 8'hC9};
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[162:0];
    endfunction

    always @(posedge clk) junk <= rnd163();

    generate
        for (genvar k = 0; k < NI; k++) begin : g_inst
            localparam int LAT = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
            gf163_mult_ctrl_if bus ();
            logic [162:0] pipe [LAT+1];

            assign bus.in_valid  = in_valid;
            assign bus.in_a      = in_a;
            assign bus.in_b      = in_b;
            assign bus.out_ready = out_ready;
            assign rdy_w[k] = bus.in_ready;
            assign ov_w[k]  = bus.out_valid;
            assign iss_w[k] = bus.mul_issue;
            assign oc_w[k]  = bus.out_c;

            gf163_mult_ctrl #(.MUL_LAT(LAT)) dut (
                .clk_i  (clk),
                .rst_i  (rst),
                .bus_io (bus.slave)
            );

            // Multiplier model: idle slots carry random junk so only tag-aligned captures give right answers
            if (LAT == 0) begin : g_comb
                assign bus.mul_d = bus.mul_issue ? clmul(bus.mul_a, bus.mul_b) : junk;
            end else begin : g_pipe
                always @(posedge clk) begin
                    pipe[0] <= bus.mul_issue ? clmul(bus.mul_a, bus.mul_b) : rnd163();
                    for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
                end
                assign bus.mul_d = pipe[LAT-1];
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [162:0] a, input logic [162:0] b, input logic ordy);
        int w;
        @(negedge clk);
        w = 0;
        while (!(rdy_w[0] && rdy_w[1] && rdy_w[2]) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("idle_timeout", 163'(0), 163'(1));
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        t0        = cyc;
        for (int k = 0; k < NI; k++) begin
            done[k] = 1'b0; iss_cnt[k] = 0; iss_first[k] = -1; iss_last[k] = -1;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 0; k < NI; k++) begin
                if (iss_w[k]) begin
                    iss_cnt[k]++;
                    if (iss_first[k] < 0) iss_first[k] = cyc;
                    iss_last[k] = cyc;
                end
                if (ov_w[k] && !done[k]) begin
                    done[k]    = 1'b1;
                    got_c[k]   = oc_w[k];
                    got_lat[k] = cyc - t0;
                end
            end
            if (done[0] && done[1] && done[2]) break;
        end
        for (int k = 0; k < NI; k++)
            if (!done[k]) chk($sformatf("out_valid_timeout/lat%0d", lat_of(k)), 163'(0), 163'(1));
    endtask

    task automatic check_op(input string nm, input logic [162:0] exp);
        for (int k = 0; k < NI; k++) begin
            if (done[k]) begin
                chk($sformatf("%s/c/lat%0d", nm, lat_of(k)), got_c[k], exp);
                chk($sformatf("%s/latency/lat%0d", nm, lat_of(k)), 163'(got_lat[k]), 163'(lat_of(k) + 5));
            end
        end
    endtask

    initial begin
        vec_t tbl [9];
        logic [162:0] x162, x81, x82, ones, ra, rb, exp;

        x162 = 163'b1 << 162;
        x81  = 163'b1 << 81;
        x82  = 163'b1 << 82;
        ones = '1;
        tbl[0] = '{a: 163'd1, b: 163'd1, c: 163'd1};
        tbl[1] = '{a: x162, b: 163'h2, c: 163'hC9};
        tbl[2] = '{a: x162, b: x162, c: ref_mul(x162, x162)};
        tbl[3] = '{a: x162, b: 163'h4, c: 163'h192};
        tbl[4] = '{a: 163'h3, b: 163'h5, c: 163'hF};
        tbl[5] = '{a: ones, b: 163'd1, c: ones};
        tbl[6] = '{a: 163'd0, b: rnd163(), c: 163'd0};
        tbl[7] = '{a: x81, b: x81, c: x162};
        tbl[8] = '{a: x82, b: x82, c: 163'h192};

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_in_ready/lat%0d", lat_of(k)), 163'(rdy_w[k]), 163'(0));
            chk($sformatf("rst_out_valid/lat%0d", lat_of(k)), 163'(ov_w[k]), 163'(0));
            chk($sformatf("rst_out_c/lat%0d", lat_of(k)), oc_w[k], 163'(0));
            chk($sformatf("rst_mul_issue/lat%0d", lat_of(k)), 163'(iss_w[k]), 163'(0));
        end
        chk("rst_mul_a", 163'(g_inst[1].bus.mul_a), 163'(0));
        chk("rst_mul_b", 163'(g_inst[1].bus.mul_b), 163'(0));
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk($sformatf("post_rst_in_ready/lat%0d", lat_of(k)), 163'(rdy_w[k]), 163'(1));

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, 1'b1);
            check_op($sformatf("tbl%0d", i), tbl[i].c);
            if (i == 0) begin
                for (int k = 0; k < NI; k++) begin
                    chk($sformatf("issue_count/lat%0d", lat_of(k)), 163'(iss_cnt[k]), 163'(3));
                    chk($sformatf("issue_span/lat%0d", lat_of(k)), 163'(iss_last[k] - iss_first[k]), 163'(2));
                    chk($sformatf("issue_start/lat%0d", lat_of(k)), 163'(iss_first[k] - t0), 163'(1));
                end
            end
        end

        // Random operands against the bit-serial reference
        for (int i = 0; i < 1000; i++) begin
            ra = rnd163();
            rb = rnd163();
            run_op(ra, rb, 1'b1);
            check_op($sformatf("rand%0d", i), ref_mul(ra, rb));
        end

        // Backpressure: result held, new operands ignored
        ra  = rnd163();
        rb  = rnd163();
        exp = ref_mul(ra, rb);
        run_op(ra, rb, 1'b0);
        check_op("bp", exp);
        for (int n = 0; n < 20; n++) begin
            in_valid = n[0];
            in_a     = rnd163();
            in_b     = rnd163();
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("bp_out_valid/lat%0d", lat_of(k)), 163'(ov_w[k]), 163'(1));
                chk($sformatf("bp_in_ready/lat%0d", lat_of(k)), 163'(rdy_w[k]), 163'(0));
                chk($sformatf("bp_out_c/lat%0d", lat_of(k)), oc_w[k], exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("bp_release_ready/lat%0d", lat_of(k)), 163'(rdy_w[k]), 163'(1));
            chk($sformatf("bp_release_valid/lat%0d", lat_of(k)), 163'(ov_w[k]), 163'(0));
        end
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                chk($sformatf("bp_no_ghost/lat%0d", lat_of(k)), 163'(ov_w[k]), 163'(0));
        end

        // Reset while the MUL_LAT=3 instance waits for its products
        in_valid = 1'b1;
        in_a     = rnd163();
        in_b     = rnd163();
        t0       = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_no_issue", 163'(iss_w[2]), 163'(0));
        chk("wait_no_valid", 163'(ov_w[2]), 163'(0));
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("midrst_in_ready/lat%0d", lat_of(k)), 163'(rdy_w[k]), 163'(0));
            chk($sformatf("midrst_out_c/lat%0d", lat_of(k)), oc_w[k], 163'(0));
            chk($sformatf("midrst_issue/lat%0d", lat_of(k)), 163'(iss_w[k]), 163'(0));
        end
        chk("midrst_mul_a", 163'(g_inst[2].bus.mul_a), 163'(0));
        chk("midrst_mul_b", 163'(g_inst[2].bus.mul_b), 163'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk($sformatf("midrst_release_ready/lat%0d", lat_of(k)), 163'(rdy_w[k]), 163'(1));
        run_op(163'h3, 163'h5, 1'b1);
        check_op("after_rst", 163'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
